alu_seq: RTL and testbench

//  Arithmetic/logic unit for the 8-bit datapath. Sits directly downstream of
//  the accumulator and B register: consumes their direct outputs (a, b).

---
 rtl/alu_seq_if.sv | 32 +++
 rtl/alu_seq.sv | 146 ++++++++++++++
 tb/tb_alu_seq.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Bus-control encoding shared with the sequencer, and the ALU's operand/result bundle.
// The sequencer/bench side takes the master modport; the ALU takes the slave modport.
package control;
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    LOAD   = 2'd1,
    STORE  = 2'd2,
    ENABLE = 2'd3
  } memory_op_e;
endpackage

interface alu_seq_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2:0]         alu_op;
  logic               start;
  control::memory_op_e op;
  logic [WIDTH-1:0]   out;
  logic               busy;
  logic               flag_zero;
  logic               flag_carry;

  modport master (
    output a, b, alu_op, start, op,
    input  out, busy, flag_zero, flag_carry
  );

  modport slave (
    input  a, b, alu_op, start, op,
    output out, busy, flag_zero, flag_carry
  );
endinterface

// File: rtl/alu_seq.sv
// 8-bit ALU: logic/add/shift ops write the result one edge after start; MUL is a
// WIDTH-cycle shift-add with busy high throughout, and start is dropped while busy.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic      clock,
  input  logic      reset,
  alu_seq_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  state_e             state, state_nxt;
  logic [WIDTH-1:0]   result, result_nxt;
  logic               zero_q, zero_nxt;
  logic               carry_q, carry_nxt;
  logic [2*WIDTH-1:0] mcand, mcand_nxt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   mplier, mplier_nxt;
  logic [CW-1:0]      count, count_nxt;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic [2*WIDTH-1:0] acc_step;

  // Single-cycle datapath; MUL falls through to the defaults and is unused here.
  always_comb begin
    sum       = {1'b0, bus.a} + {1'b0, bus.b};
    diff      = {1'b0, bus.a} - {1'b0, bus.b};
    alu_res   = '0;
    alu_carry = 1'b0;
    case (bus.alu_op)
      OP_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      OP_SUB: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
      end
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_SHL: begin
        alu_res   = bus.a << 1;
        alu_carry = bus.a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res   = bus.a >> 1;
        alu_carry = bus.a[0];
      end
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  assign acc_step = mplier[0] ? (acc + mcand) : acc;

  always_comb begin
    state_nxt  = state;
    result_nxt = result;
    zero_nxt   = zero_q;
    carry_nxt  = carry_q;
    mcand_nxt  = mcand;
    acc_nxt    = acc;
    mplier_nxt = mplier;
    count_nxt  = count;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.alu_op == OP_MUL) begin
            mcand_nxt  = {{WIDTH{1'b0}}, bus.a};
            mplier_nxt = bus.b;
            acc_nxt    = '0;
            count_nxt  = '0;
            state_nxt  = S_MUL;
          end else begin
            result_nxt = alu_res;
            zero_nxt   = (alu_res == '0);
            carry_nxt  = alu_carry;
          end
        end
      end
      S_MUL: begin
        acc_nxt    = acc_step;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
        count_nxt  = count + 1'b1;
        // Final step: commit the low half, flag any overflow into the high half.
        if (count == CW'(WIDTH - 1)) begin
          state_nxt  = S_IDLE;
          result_nxt = acc_step[WIDTH-1:0];
          zero_nxt   = (acc_step[WIDTH-1:0] == '0);
          carry_nxt  = |acc_step[2*WIDTH-1:WIDTH];
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      result  <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      count   <= '0;
    end else begin
      state   <= state_nxt;
      result  <= result_nxt;
      zero_q  <= zero_nxt;
      carry_q <= carry_nxt;
      mcand   <= mcand_nxt;
      acc     <= acc_nxt;
      mplier  <= mplier_nxt;
      count   <= count_nxt;
    end
  end

  assign bus.busy       = (state == S_MUL);
  assign bus.flag_zero  = zero_q;
  assign bus.flag_carry = carry_q;
  assign bus.out        = (bus.op == control::ENABLE) ? result : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: vector table, hand-built MUL/reset sequences, and random ops
// checked against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
    logic       c;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_ne(input string name, input logic [31:0] act, input logic [31:0] bad);
    checks++;
    if (act === bad) begin
      errors++;
      $display("FAIL %s: got %0h expected anything but %0h", name, act, bad);
    end
  endtask

  // Reference model from the arithmetic definitions, not the RTL structure.
  function automatic void model(input int op, input int a, input int b,
                                output int res, output int c);
    int t;
    res = 0;
    c   = 0;
    case (op)
      0: begin t = a + b; res = t % 256; c = (t > 255) ? 1 : 0; end
      1: begin res = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: begin res = (a * 2) % 256; c = a / 128; end
      6: begin res = a / 2; c = a % 2; end
      default: begin t = a * b; res = t % 256; c = ((t / 256) != 0) ? 1 : 0; end
    endcase
  endfunction

  // Pulses start for one edge; returns the number of cycles busy was seen high.
  task automatic issue(input int op, input int a, input int b, output int nbusy);
    @(negedge clock);
    bus.a      = a[7:0];
    bus.b      = b[7:0];
    bus.alu_op = op[2:0];
    bus.start  = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    nbusy = 0;
    while (bus.busy === 1'b1 && nbusy < 40) begin
      nbusy++;
      @(negedge clock);
    end
  endtask

  task automatic exec_model(input string name, input int op, input int a, input int b);
    int nb, res, c;
    issue(op, a, b, nb);
    model(op, a, b, res, c);
    check({name, "_busy_cycles"}, nb, (op == 7) ? W : 0);
    check({name, "_out"}, bus.out, res);
    check({name, "_zero"}, bus.flag_zero, (res == 0) ? 1 : 0);
    check({name, "_carry"}, bus.flag_carry, c);
  endtask

  initial begin
    int nb;
    reset      = 1'b1;
    bus.a      = '0;
    bus.b      = '0;
    bus.alu_op = '0;
    bus.start  = 1'b0;
    bus.op     = control::ENABLE;

    vecs[0]  = '{3'd0, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1};
    vecs[1]  = '{3'd2, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{3'd1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{3'd1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1};
    vecs[4]  = '{3'd5, 8'h81, 8'h00, 8'h02, 1'b0, 1'b1};
    vecs[5]  = '{3'd7, 8'h0C, 8'h0B, 8'h84, 1'b0, 1'b0};
    vecs[6]  = '{3'd7, 8'h20, 8'h10, 8'h00, 1'b1, 1'b1};
    vecs[7]  = '{3'd3, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0};
    vecs[8]  = '{3'd4, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0};
    vecs[9]  = '{3'd6, 8'h03, 8'h00, 8'h01, 1'b0, 1'b1};
    vecs[10] = '{3'd7, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b1};
    vecs[11] = '{3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0};

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("reset_out", bus.out, 8'h00);
    check("reset_zero", bus.flag_zero, 1'b0);
    check("reset_carry", bus.flag_carry, 1'b0);
    check("reset_busy", bus.busy, 1'b0);

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, nb);
      check($sformatf("vec%0d_busy_cycles", i), nb, (vecs[i].op == 3'd7) ? W : 0);
      check($sformatf("vec%0d_out", i), bus.out, vecs[i].res);
      check($sformatf("vec%0d_zero", i), bus.flag_zero, vecs[i].z);
      check($sformatf("vec%0d_carry", i), bus.flag_carry, vecs[i].c);
    end

    // Bus released when op is not ENABLE (last result is 0x80).
    @(negedge clock);
    bus.op = control::LOAD;
    #1;
    check_ne("load_releases_bus", bus.out, 8'h80);
    bus.op = control::ENABLE;

    // Start and operand changes during MUL are ignored; bus shows the old result.
    issue(0, 1, 2, nb);
    check("pre_mul_out", bus.out, 8'h03);
    @(negedge clock);
    bus.a = 8'h0C; bus.b = 8'h0B; bus.alu_op = 3'd7; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    bus.a = 8'hFF; bus.b = 8'hFF;
    check("mul_busy_start", bus.busy, 1'b1);
    @(negedge clock);
    bus.alu_op = 3'd0; bus.start = 1'b1;
    check("busy_out_prev", bus.out, 8'h03);
    @(negedge clock);
    bus.start = 1'b0;
    check("busy_flags_held", {bus.flag_zero, bus.flag_carry}, 2'b00);
    nb = 2;
    while (bus.busy === 1'b1 && nb < 40) begin
      nb++;
      @(negedge clock);
    end
    check("ignored_start_busy_cycles", nb, W);
    check("ignored_start_out", bus.out, 8'h84);
    check("ignored_start_carry", bus.flag_carry, 1'b0);

    // Reset on the 4th MUL cycle aborts without writing a result.
    @(negedge clock);
    bus.a = 8'h0C; bus.b = 8'h0B; bus.alu_op = 3'd7; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (3) @(negedge clock);
    check("mul_busy_cycle4", bus.busy, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_out", bus.out, 8'h00);
    check("abort_flags", {bus.flag_zero, bus.flag_carry}, 2'b00);
    repeat (10) @(negedge clock);
    check("abort_no_late_write", bus.out, 8'h00);
    check("abort_stays_idle", bus.busy, 1'b0);

    // Start coinciding with reset is discarded.
    issue(0, 1, 1, nb);
    check("pre_reset_add", bus.out, 8'h02);
    @(negedge clock);
    bus.a = 8'h03; bus.b = 8'h04; bus.alu_op = 3'd0; bus.start = 1'b1; reset = 1'b1;
    @(negedge clock);
    bus.start = 1'b0; reset = 1'b0;
    check("start_reset_out", bus.out, 8'h00);
    check("start_reset_busy", bus.busy, 1'b0);
    @(negedge clock);
    bus.alu_op = 3'd7; bus.start = 1'b1; reset = 1'b1;
    @(negedge clock);
    bus.start = 1'b0; reset = 1'b0;
    check("start_reset_mul_busy", bus.busy, 1'b0);

    for (int i = 0; i < 150; i++) begin
      exec_model($sformatf("rand%0d", i), $urandom_range(0, 7),
                 $urandom_range(0, 255), $urandom_range(0, 255));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
